// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM states, the NOP encoding and the wait-counter width helper.
package imem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [31:0] IMEM_NOP = 32'h00000013;
  function automatic int cnt_width(input int wait_states);
    return (wait_states < 2) ? 1 : $clog2(wait_states + 1);
  endfunction
endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-clock RAM, one synchronous read-before-write read port and one write port.
module imem_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);
  logic [31:0] mem [DEPTH_WORDS];
  // Only the read register is reset; the array keeps its image across reset.
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: single-outstanding instruction fetch responder with wait states and flush.
// Define IMEM_MISALIGN_CHECK_EN to answer misaligned requests with resp_err and a NOP.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [31:0]   req_addr,
  output logic          req_ready,
  input  logic          flush,
  output logic          resp_valid,
  output logic [31:0]   resp_data,
  output logic [31:0]   resp_addr,
  output logic          resp_err,
  input  logic          resp_ready,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);
  localparam int CW = cnt_width(WAIT_STATES);
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, ram_q;
  logic err_q, accept, mis, ram_re, unused;
`ifdef IMEM_MISALIGN_CHECK_EN
  assign mis = |req_addr[1:0];
`else
  assign mis = 1'b0;
`endif
  assign unused = ^{req_addr[31:AW+2], req_addr[1:0], addr_q[31:AW+2], addr_q[1:0]};
  assign req_ready = reset && state == IDLE && !flush;
  assign accept = req_valid && req_ready;
  assign resp_valid = state == RESP;
  assign resp_addr = addr_q;
  assign resp_err = err_q;
  assign resp_data = err_q ? IMEM_NOP : ram_q;
  always_comb begin
    next = state;
    ram_re = 1'b0;
    case (state)
      IDLE: begin
        next = accept ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE;
        ram_re = accept && WAIT_STATES == 0 && !mis;
      end
      WAIT: begin
        next = flush ? IDLE : (cnt == CW'(1)) ? RESP : WAIT;
        ram_re = !flush && cnt == CW'(1) && !err_q;
      end
      default: next = (flush || resp_ready) ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        addr_q <= req_addr;
        cnt    <= CW'(WAIT_STATES);
        err_q  <= mis;
      end else if (state == WAIT) cnt <= cnt - 1'b1;
    end
  imem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk(clk), .reset(reset), .re(ram_re),
    .raddr(state == IDLE ? req_addr[AW+1:2] : addr_q[AW+1:2]),
    .rdata(ram_q), .we(ld_en), .waddr(ld_addr), .wdata(ld_data)
  );
endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Instruction-memory responder: the far end of the program counter's fetch request. Accepts one word-address request at a time from the fetch stage, reads the instruction word from an internal synchronous RAM after a configurable number of wait states, and holds the result until the fetch stage takes it. A `flush` input discards an in-flight fetch when the PC is redirected by a branch or jump. A load port lets the bench or boot logic write the program image.

## Interface
- `DEPTH_WORDS`, 256: RAM depth in 32-bit words; must be a power of two, ≥ 4.
- `WAIT_STATES`, 1: extra cycles between request acceptance and response; legal range 0–15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; asserting it clears all state immediately.
- `req_valid` in 1: fetch request present.
- `req_addr` in 32: byte address of the instruction.
- `req_ready` out 1: request is accepted on a cycle where `req_valid` and `req_ready` are both high.
- `flush` in 1: abandon any pending fetch.
- `resp_valid` out 1: response available.
- `resp_data` out 32: instruction word.
- `resp_addr` out 32: `req_addr` of the request being answered.
- `resp_err` out 1: misaligned request; see Configuration.
- `resp_ready` in 1: fetch stage consumes the response.
- `ld_en` in 1: RAM write strobe.
- `ld_addr` in log2(DEPTH_WORDS): word index to write.
- `ld_data` in 32: word to write.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = `!flush`.
  - On acceptance: latch `req_addr` and load the wait counter with `WAIT_STATES`.
  - Go to WAIT if `WAIT_STATES > 0`; otherwise issue the RAM read now and go to RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, issue the RAM read and go to RESP on the next edge.
- **RESP**
  - `resp_valid` = 1; `resp_data`, `resp_addr` and `resp_err` are held stable.
  - On `resp_valid && resp_ready`, go to IDLE.
  - No bypass: a new request is accepted at the earliest on the cycle after the handshake.
- **Addressing:** word index = `req_addr[log2(DEPTH_WORDS)+1:2]`. Higher bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- **Flush:** in WAIT or RESP, `flush` forces IDLE on the next edge. `resp_valid` drops and the response is discarded even if `resp_ready` is high in the same cycle. In IDLE, `flush` blocks acceptance for that cycle.
- **Load port:**
  - Writes on any cycle in any state.
  - The RAM is read-before-write: a read and a write to the same word in the same cycle returns the old value.
  - A write after the read cycle does not alter an already-captured `resp_data`.
- **Reset:** state = IDLE, counter = 0; `resp_valid`, `resp_err` and `req_ready` = 0 while `reset` is low. `resp_data` and `resp_addr` = 0. RAM contents are not cleared. `req_ready` rises on the first cycle after release.

## Timing
- Request accepted at edge N → `resp_valid` high during cycle N+1+`WAIT_STATES`.
- Minimum request-to-request spacing is 2+`WAIT_STATES` cycles (one outstanding request).
- `resp_*` are registered outputs. `req_ready` is combinational from the state and `flush` only.

## Configuration
- **`IMEM_MISALIGN_CHECK_EN` defined:** if `req_addr[1:0] != 0`, the RAM is not read. The response carries `resp_err` = 1 and `resp_data` = 32'h00000013 (NOP), with the same latency.
- **Undefined:** `req_addr[1:0]` is ignored, `resp_err` is tied to 0, and a misaligned address reads the containing word.

## Structure
- **Package `imem_pkg`:** FSM state enum, `IMEM_NOP` = 32'h00000013, and a function computing the counter width from `WAIT_STATES`.
- **Sub-module `imem_ram`:** single-clock, one synchronous read port and one write port, read-before-write, parameter `DEPTH_WORDS`. The FSM, counter and output registers stay in `imem_fetch_responder`.

## Test plan
- **Basic fetch:** `WAIT_STATES`=1; load word 3 = 32'h00500093, request `req_addr`=32'hC at edge N → `resp_valid` in cycle N+2 with `resp_data`=32'h00500093 and `resp_addr`=32'hC; `req_ready`=0 until the cycle after `resp_ready`.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles → `resp_valid` and `resp_data` are stable throughout; a second `req_valid` is not accepted.
- **Flush:** flush during WAIT → no `resp_valid` for that request; `req_ready`=1 the following cycle. Flush in RESP with `resp_ready`=1 → response dropped, no handshake counted.
- **Wrap:** `DEPTH_WORDS`=256, request 32'h00000404 → returns word 1.
- **Misalign:** request 32'h6 → with `IMEM_MISALIGN_CHECK_EN`, `resp_err`=1 and `resp_data`=32'h00000013; without it, word 1 and `resp_err`=0.
- **Reset and load collision:** assert `reset` low in WAIT → outputs 0 and IDLE immediately; RAM keeps its contents. Separately, `ld_en` to the same word in the read cycle → the old value is returned.
